// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: majority voter with scrub write-back for a triplicated register.
// Registers the three replica words, votes them and, when a replica disagrees
// with the majority, pulses scrub_en for that lane so the replica reloads the
// voted word. A lane still wrong after MAX_RETRY scrubs is flagged stuck.
// Optional feature macro: TMR_SCRUB_ERR_CNT_EN builds the per-lane saturating
// mismatch-episode counters; without it port_err_cnt_0..2 are tied to zero.
module tmr_scrub_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     port_in_0,
  input  logic [WIDTH-1:0]     port_in_1,
  input  logic [WIDTH-1:0]     port_in_2,
  input  logic                 port_clr_err,
  output logic [WIDTH-1:0]     port_voted_out,
  output logic [2:0]           port_scrub_en,
  output logic [WIDTH-1:0]     port_scrub_data,
  output logic [2:0]           port_stuck,
  output logic                 port_uncorr,
  output logic [ERR_CNT_W-1:0] port_err_cnt_0,
  output logic [ERR_CNT_W-1:0] port_err_cnt_1,
  output logic [ERR_CNT_W-1:0] port_err_cnt_2
);

  localparam int unsigned RETRY_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCRUB = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  logic [WIDTH-1:0]   r0, r1, r2;
  logic [WIDTH-1:0]   v;
  logic [2:0]         m;

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               wait_q, wait_d;
  logic [2:0]         scrub_en_d;
  logic [WIDTH-1:0]   scrub_data_d;
  logic [2:0]         stuck_d;
  logic               uncorr_d;

  // Bitwise majority of the registered replicas and per-lane disagreement mask
  always_comb begin
    v    = (r0 & r1) | (r1 & r2) | (r2 & r0);
    m[0] = (r0 != v);
    m[1] = (r1 != v);
    m[2] = (r2 != v);
  end

  // Input registers, voted output, FSM state and registered scrub/flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r0              <= '0;
      r1              <= '0;
      r2              <= '0;
      port_voted_out  <= '0;
      state_q         <= S_IDLE;
      retry_q         <= '0;
      wait_q          <= 1'b0;
      port_scrub_en   <= '0;
      port_scrub_data <= '0;
      port_stuck      <= '0;
      port_uncorr     <= 1'b0;
    end else begin
      r0              <= port_in_0;
      r1              <= port_in_1;
      r2              <= port_in_2;
      port_voted_out  <= v;
      state_q         <= state_d;
      retry_q         <= retry_d;
      wait_q          <= wait_d;
      port_scrub_en   <= scrub_en_d;
      port_scrub_data <= scrub_data_d;
      port_stuck      <= stuck_d;
      port_uncorr     <= uncorr_d;
    end
  end

  // Next-state logic; scrub_en_d is the latched mask M, only nonzero on entry to SCRUB
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    wait_d       = 1'b0;
    scrub_en_d   = '0;
    scrub_data_d = port_scrub_data;
    stuck_d      = port_stuck;
    uncorr_d     = port_uncorr;

    case (state_q)
      S_IDLE: begin
        if (m != 3'b000) begin
          scrub_en_d   = m;
          scrub_data_d = v;
          if (m == 3'b111) uncorr_d = 1'b1;
          state_d      = S_SCRUB;
        end
      end
      S_SCRUB: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // First cycle covers the replica reload, second the input register
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (m == 3'b000) begin
          retry_d = '0;
          state_d = S_IDLE;
        end else if (retry_q < RETRY_W'(MAX_RETRY - 1)) begin
          retry_d      = retry_q + RETRY_W'(1);
          scrub_en_d   = m;
          scrub_data_d = v;
          state_d      = S_SCRUB;
        end else begin
          stuck_d = port_stuck | m;
          retry_d = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if ((m == 3'b000) || port_clr_err) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (port_clr_err) begin
      stuck_d  = '0;
      uncorr_d = 1'b0;
    end
  end

`ifdef TMR_SCRUB_ERR_CNT_EN
  logic [2:0]           bump;
  logic [ERR_CNT_W-1:0] cnt_q [3];

  // A lane bumps once per episode, when IDLE first sees it disagree
  assign bump = (state_q == S_IDLE) ? m : 3'b000;

  // Saturating per-lane episode counters; clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst || port_clr_err) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bump[i] && (cnt_q[i] != {ERR_CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign port_err_cnt_0 = cnt_q[0];
  assign port_err_cnt_1 = cnt_q[1];
  assign port_err_cnt_2 = cnt_q[2];
`else
  assign port_err_cnt_0 = '0;
  assign port_err_cnt_1 = '0;
  assign port_err_cnt_2 = '0;
`endif

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed testbench for tmr_scrub_ctrl. The bench plays the three replicas:
// it drives port_in_0..2 and reloads them (or not) when it sees scrub_en.
module tb_tmr_scrub_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 8;
`ifdef TMR_SCRUB_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in0, in1, in2;
  logic             clr_err;
  logic [WIDTH-1:0] voted;
  logic [2:0]       scrub_en;
  logic [WIDTH-1:0] scrub_data;
  logic [2:0]       stuck;
  logic             uncorr;
  logic [CW-1:0]    cnt0, cnt1, cnt2;

  int tests = 0;
  int fails = 0;

  tmr_scrub_ctrl #(.WIDTH(WIDTH), .ERR_CNT_W(CW), .MAX_RETRY(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .port_in_0       (in0),
    .port_in_1       (in1),
    .port_in_2       (in2),
    .port_clr_err    (clr_err),
    .port_voted_out  (voted),
    .port_scrub_en   (scrub_en),
    .port_scrub_data (scrub_data),
    .port_stuck      (stuck),
    .port_uncorr     (uncorr),
    .port_err_cnt_0  (cnt0),
    .port_err_cnt_1  (cnt1),
    .port_err_cnt_2  (cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected counter value: saturating count when counters are built, else 0
  function automatic logic [31:0] exp_cnt(input int n);
    if (!CNT_EN) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  // Step negedges until scrub_en is nonzero or the budget runs out
  task automatic wait_scrub(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scrub_en != 3'b000) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  // Count cycles with scrub_en active over a fixed window
  task automatic count_pulses(input int n, output int pulses, output logic [2:0] en_or);
    pulses = 0;
    en_or  = 3'b000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (scrub_en != 3'b000) pulses++;
      en_or = en_or | scrub_en;
    end
  endtask

  initial begin
    bit         seen;
    int         pulses;
    int         missed;
    logic [2:0] en_or;

    // Test 1: reset then steady A5
    rst = 1'b1; clr_err = 1'b0;
    in0 = 8'hA5; in1 = 8'hA5; in2 = 8'hA5;
    repeat (2) @(negedge clk);
    check("rst_voted",    32'(voted),    32'h0);
    check("rst_scrub_en", 32'(scrub_en), 32'h0);
    check("rst_stuck",    32'(stuck),    32'h0);
    check("rst_uncorr",   32'(uncorr),   32'h0);
    check("rst_cnt0",     32'(cnt0),     32'h0);
    rst = 1'b0;
    en_or = 3'b000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en_or = en_or | scrub_en;
      if (c == 1)  check("t1_voted_c1",  32'(voted), 32'h00);
      if (c == 2)  check("t1_voted_c2",  32'(voted), 32'hA5);
      if (c == 10) check("t1_voted_c10", 32'(voted), 32'hA5);
    end
    check("t1_no_scrub", 32'(en_or), 32'h0);
    check("t1_cnt_sum",  32'(cnt0) + 32'(cnt1) + 32'(cnt2), 32'h0);

    // Test 2: single-cycle upset on lane 1, bench reloads the replica
    in1 = 8'hA4;
    wait_scrub(10, seen);
    check("t2_seen",       32'(seen),       32'h1);
    check("t2_scrub_en",   32'(scrub_en),   32'h2);
    check("t2_scrub_data", 32'(scrub_data), 32'hA5);
    check("t2_voted",      32'(voted),      32'hA5);
    in1 = 8'hA5;
    count_pulses(8, pulses, en_or);
    check("t2_no_retry", 32'(pulses), 32'h0);
    check("t2_cnt1",     32'(cnt1),   exp_cnt(1));
    check("t2_stuck",    32'(stuck),  32'h0);

    // Test 3: lane 2 stuck at 00, scrubs ignored
    in0 = 8'hFF; in1 = 8'hFF; in2 = 8'h00;
    count_pulses(20, pulses, en_or);
    check("t3_pulses",     32'(pulses),     32'h2);
    check("t3_en_lanes",   32'(en_or),      32'h4);
    check("t3_scrub_data", 32'(scrub_data), 32'hFF);
    check("t3_stuck",      32'(stuck),      32'h4);
    check("t3_uncorr",     32'(uncorr),     32'h0);
    check("t3_cnt2",       32'(cnt2),       exp_cnt(1));
    count_pulses(10, pulses, en_or);
    check("t3_hold_quiet", 32'(pulses),     32'h0);
    in2 = 8'hFF;
    count_pulses(5, pulses, en_or);
    check("t3_release_quiet", 32'(pulses), 32'h0);
    check("t3_stuck_sticky",  32'(stuck),  32'h4);

    // Test 4: all lanes differ from the vote, bench reloads all three
    in0 = 8'h01; in1 = 8'h02; in2 = 8'h04;
    wait_scrub(10, seen);
    check("t4_seen",       32'(seen),       32'h1);
    check("t4_scrub_en",   32'(scrub_en),   32'h7);
    check("t4_scrub_data", 32'(scrub_data), 32'h00);
    check("t4_uncorr",     32'(uncorr),     32'h1);
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00;
    count_pulses(8, pulses, en_or);
    check("t4_no_retry", 32'(pulses), 32'h0);
    check("t4_cnt0", 32'(cnt0), exp_cnt(1));
    check("t4_cnt1", 32'(cnt1), exp_cnt(2));
    check("t4_cnt2", 32'(cnt2), exp_cnt(2));

    // Clear coinciding with an increment: clear wins
    in0 = 8'h01;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_coll_scrub_en", 32'(scrub_en), 32'h1);
    in0 = 8'h00;
    count_pulses(6, pulses, en_or);
    check("clr_coll_cnt0",   32'(cnt0),   32'h0);
    check("clr_coll_cnt1",   32'(cnt1),   32'h0);
    check("clr_coll_stuck",  32'(stuck),  32'h0);
    check("clr_coll_uncorr", 32'(uncorr), 32'h0);

    // Test 5: saturate lane 0 counter, then one more episode
    missed = 0;
    for (int e = 0; e < 256; e++) begin
      in0 = 8'h01;
      wait_scrub(10, seen);
      if (!seen) missed++;
      in0 = 8'h00;
      repeat (4) @(negedge clk);
      if (e == 254) check("t5_cnt0_at_max", 32'(cnt0), exp_cnt(255));
    end
    check("t5_all_episodes", 32'(missed), 32'h0);
    check("t5_cnt0_sat",     32'(cnt0),   exp_cnt(256));
    check("t5_cnt1_idle",    32'(cnt1),   32'h0);
    // Build stuck=111 and uncorr=1, then clear everything
    in0 = 8'h01; in1 = 8'h02; in2 = 8'h04;
    count_pulses(20, pulses, en_or);
    check("t5_uc_pulses", 32'(pulses), 32'h2);
    check("t5_uc_stuck",  32'(stuck),  32'h7);
    check("t5_uc_uncorr", 32'(uncorr), 32'h1);
    check("t5_uc_cnt1",   32'(cnt1),   exp_cnt(1));
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00;
    count_pulses(6, pulses, en_or);
    check("t5_uc_quiet", 32'(pulses), 32'h0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("t5_clr_cnt0",   32'(cnt0),   32'h0);
    check("t5_clr_cnt1",   32'(cnt1),   32'h0);
    check("t5_clr_cnt2",   32'(cnt2),   32'h0);
    check("t5_clr_stuck",  32'(stuck),  32'h0);
    check("t5_clr_uncorr", 32'(uncorr), 32'h0);

    // Test 6: reset during the second (retry) SCRUB of a persistent lane-2 fault
    in2 = 8'h0F;
    wait_scrub(10, seen);
    check("t6_first_pulse", 32'(seen), 32'h1);
    wait_scrub(10, seen);
    check("t6_retry_pulse", 32'(seen),     32'h1);
    check("t6_retry_en",    32'(scrub_en), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_scrub_en", 32'(scrub_en), 32'h0);
    check("t6_rst_voted",    32'(voted),    32'h0);
    check("t6_rst_cnt2",     32'(cnt2),     32'h0);
    rst = 1'b0;
    count_pulses(20, pulses, en_or);
    check("t6_fresh_pulses", 32'(pulses), 32'h2);
    check("t6_fresh_stuck",  32'(stuck),  32'h4);
    check("t6_fresh_cnt2",   32'(cnt2),   exp_cnt(1));
    in2 = 8'h00;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
